// File: rtl/aud_pkg.sv
// Shared defaults and types for the audio DAC transmitter.
// Define AUD_DAC_I2S_DELAY_EN for Philips I2S timing (MSB one BCLK after the LRCK edge).
package aud_pkg;

  localparam int AUD_SAMPLE_W   = 16;
  localparam int AUD_SLOT_W     = 16;
  localparam int UNDERRUN_CNT_W = 8;

  // LRCK level for each channel slot
  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } channel_t;

`ifdef AUD_DAC_I2S_DELAY_EN
  localparam int DATA_DELAY = 1;
`else
  localparam int DATA_DELAY = 0;
`endif

  // Smallest slot that still holds a whole sample after the optional delay bit
  function automatic int min_slot_w(input int sample_w);
    return sample_w + DATA_DELAY;
  endfunction

endpackage

// File: rtl/aud_bclk_gen.sv
// Bit-clock divider: AUD_BCLK toggles every CLK_DIV system clocks.
// Strobes are high in the cycle whose clock edge moves AUD_BCLK.
module aud_bclk_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic CLOCK,
  input  logic RESET,
  output logic AUD_BCLK,
  output logic bclk_rise,
  output logic bclk_fall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  generate
    if (CLK_DIV < 2) begin : g_bad_div
      $error("aud_bclk_gen: CLK_DIV must be at least 2");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt_reg;
  logic             bclk_reg;
  logic             wrap;

  assign wrap = (div_cnt_reg == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      div_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
    end else begin
      div_cnt_reg <= wrap ? '0 : div_cnt_reg + 1'b1;
      if (wrap) begin
        bclk_reg <= ~bclk_reg;
      end
    end
  end

  // Combinational so the consumer's registers change on the same edge as AUD_BCLK
  assign bclk_rise = wrap & ~bclk_reg;
  assign bclk_fall = wrap &  bclk_reg;
  assign AUD_BCLK  = bclk_reg;

endmodule

// File: rtl/aud_dac_tx.sv
// Stereo DAC serial transmitter (bus master): left-justified by default,
// Philips I2S when AUD_DAC_I2S_DELAY_EN is defined. One-pair holding register.
module aud_dac_tx
  import aud_pkg::*;
#(
  parameter int CLK_DIV  = 16,
  parameter int SAMPLE_W = AUD_SAMPLE_W,
  parameter int SLOT_W   = AUD_SLOT_W
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic [SAMPLE_W-1:0]       s_left,
  input  logic [SAMPLE_W-1:0]       s_right,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      AUD_BCLK,
  output logic                      AUD_DACLRCK,
  output logic                      AUD_DACDAT,
  output logic                      frame_start,
  output logic                      underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);

  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int WORD_SHIFT = SLOT_W - SAMPLE_W - DATA_DELAY;

  generate
    if (SLOT_W < min_slot_w(SAMPLE_W)) begin : g_bad_slot
      $error("aud_dac_tx: SLOT_W too small for SAMPLE_W and data delay");
    end
  endgenerate

  logic                      bclk_rise;
  logic                      bclk_fall;
  logic                      unused_rise;

  logic [BIT_W-1:0]          bit_cnt_reg;
  logic [BIT_W-1:0]          bit_cnt_next;
  logic                      hold_full_reg;
  logic [SAMPLE_W-1:0]       hold_left_reg;
  logic [SAMPLE_W-1:0]       hold_right_reg;
  logic [SLOT_W-1:0]         left_sr_reg;
  logic [SLOT_W-1:0]         right_sr_reg;
  logic [FRAME_BITS-1:0]     pair_next;
  channel_t                  lrck_reg;
  logic                      dacdat_reg;
  logic                      s_ready_reg;
  logic                      frame_start_reg;
  logic                      underrun_reg;
  logic [UNDERRUN_CNT_W-1:0] underrun_cnt_reg;
  logic                      xfer;
  logic                      frame_load;

  aud_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .AUD_BCLK  (AUD_BCLK),
    .bclk_rise (bclk_rise),
    .bclk_fall (bclk_fall)
  );

  // Codec samples on the rising edge; nothing here reacts to it
  assign unused_rise = bclk_rise;

  // Place a sample in its slot so the MSB lands on slot bit DATA_DELAY, padding zero
  function automatic logic [SLOT_W-1:0] slot_word(input logic [SAMPLE_W-1:0] s);
    return SLOT_W'(s) << WORD_SHIFT;
  endfunction

  assign xfer = s_valid & s_ready_reg;

  always_comb begin
    bit_cnt_next = (bit_cnt_reg == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt_reg + 1'b1;
    frame_load   = bclk_fall && (bit_cnt_next == '0);
    pair_next    = {left_sr_reg, right_sr_reg};
    if (frame_load) begin
      if (hold_full_reg) begin
        pair_next = {slot_word(hold_left_reg), slot_word(hold_right_reg)};
      end else begin
        pair_next = '0;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      bit_cnt_reg      <= BIT_W'(FRAME_BITS - 1);
      hold_full_reg    <= 1'b0;
      hold_left_reg    <= '0;
      hold_right_reg   <= '0;
      left_sr_reg      <= '0;
      right_sr_reg     <= '0;
      lrck_reg         <= RIGHT;
      dacdat_reg       <= 1'b0;
      s_ready_reg      <= 1'b1;
      frame_start_reg  <= 1'b0;
      underrun_reg     <= 1'b0;
      underrun_cnt_reg <= '0;
    end else begin
      frame_start_reg <= 1'b0;
      underrun_reg    <= 1'b0;

      // A transfer never meets a frame load: loading needs a full register, i.e. s_ready low
      if (xfer) begin
        hold_left_reg  <= s_left;
        hold_right_reg <= s_right;
        hold_full_reg  <= 1'b1;
        s_ready_reg    <= 1'b0;
      end

      if (bclk_fall) begin
        bit_cnt_reg                 <= bit_cnt_next;
        dacdat_reg                  <= pair_next[FRAME_BITS-1];
        {left_sr_reg, right_sr_reg} <= pair_next << 1;
        if (frame_load) begin
          lrck_reg        <= LEFT;
          frame_start_reg <= 1'b1;
          if (hold_full_reg) begin
            hold_full_reg <= 1'b0;
            s_ready_reg   <= 1'b1;
          end else begin
            underrun_reg <= 1'b1;
            if (underrun_cnt_reg != '1) begin
              underrun_cnt_reg <= underrun_cnt_reg + 1'b1;
            end
          end
        end else if (bit_cnt_next == BIT_W'(SLOT_W)) begin
          lrck_reg <= RIGHT;
        end
      end
    end
  end

  assign s_ready      = s_ready_reg;
  assign AUD_DACLRCK  = lrck_reg;
  assign AUD_DACDAT   = dacdat_reg;
  assign frame_start  = frame_start_reg;
  assign underrun     = underrun_reg;
  assign underrun_cnt = underrun_cnt_reg;

endmodule

// File: tb/tb_aud_dac_tx.sv
// Randomized self-checking bench for aud_dac_tx against a frame-arithmetic reference model.
// Honours AUD_DAC_I2S_DELAY_EN (slot widened to 17 bits in that build).
module tb_aud_dac_tx;

  localparam int CD = 2;
  localparam int SW = 16;
`ifdef AUD_DAC_I2S_DELAY_EN
  localparam int SL  = 17;
  localparam int OFF = 1;
  localparam logic [SW-1:0] FIRST_L = 16'h8000;
`else
  localparam int SL  = 16;
  localparam int OFF = 0;
  localparam logic [SW-1:0] FIRST_L = 16'hA5C3;
`endif
  localparam logic [SW-1:0] FIRST_R  = 16'h8001;
  localparam int FALL_PER = 2 * CD;
  localparam int SLOTS2   = 2 * SL;
  localparam int FRAME    = SLOTS2 * FALL_PER;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic [SW-1:0] s_left, s_right;
  logic          s_valid;
  logic          s_ready, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, frame_start, underrun;
  logic [7:0]    underrun_cnt;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Reference model state
  int            t;
  bit            m_full;
  logic [SW-1:0] m_hold_l, m_hold_r, cur_l, cur_r;
  logic          e_dac, e_fs, e_ur;
  int            e_cnt;
  int            xfer_no = 0;

  always #5 CLOCK = ~CLOCK;

  aud_dac_tx #(
    .CLK_DIV  (CD),
    .SAMPLE_W (SW),
    .SLOT_W   (SL)
  ) dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .s_left       (s_left),
    .s_right      (s_right),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_DACLRCK  (AUD_DACLRCK),
    .AUD_DACDAT   (AUD_DACDAT),
    .frame_start  (frame_start),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
    end
  endtask

  function automatic logic slot_bit(input logic [SW-1:0] s, input int k);
    int idx;
    idx = k - OFF;
    if (idx < 0 || idx >= SW) return 1'b0;
    return s[SW-1-idx];
  endfunction

  function automatic logic exp_bclk();
    return ((t / CD) % 2) == 1;
  endfunction

  function automatic logic exp_lrck();
    int f;
    f = t / FALL_PER;
    if (f == 0) return 1'b1;
    return ((f - 1) % SLOTS2) >= SL;
  endfunction

  // t = clock edges since reset release; every FALL_PER-th edge is a BCLK fall
  task automatic model_update();
    bit xfer;
    int p;
    e_fs = 1'b0;
    e_ur = 1'b0;
    if (RESET) begin
      t = 0; m_full = 0; cur_l = '0; cur_r = '0; e_dac = 1'b0; e_cnt = 0;
      return;
    end
    xfer = s_valid && !m_full;
    t++;
    if (t % FALL_PER == 0) begin
      p = (t / FALL_PER - 1) % SLOTS2;
      if (p == 0) begin
        e_fs = 1'b1;
        if (m_full) begin
          cur_l = m_hold_l; cur_r = m_hold_r; m_full = 0;
        end else begin
          cur_l = '0; cur_r = '0; e_ur = 1'b1;
          if (e_cnt < 255) e_cnt++;
        end
      end
      e_dac = (p < SL) ? slot_bit(cur_l, p) : slot_bit(cur_r, p - SL);
    end
    if (xfer) begin
      m_full = 1; m_hold_l = s_left; m_hold_r = s_right;
      xfer_no++;
      $display("xfer %0d: L=%h R=%h at t=%0d", xfer_no, s_left, s_right, t);
    end
  endtask

  task automatic compare_all();
    check_val("bclk",     32'(AUD_BCLK),     32'(exp_bclk()));
    check_val("lrck",     32'(AUD_DACLRCK),  32'(exp_lrck()));
    check_val("dacdat",   32'(AUD_DACDAT),   32'(e_dac));
    check_val("s_ready",  32'(s_ready),      32'(!m_full));
    check_val("fstart",   32'(frame_start),  32'(e_fs));
    check_val("underrun", 32'(underrun),     32'(e_ur));
    check_val("ur_cnt",   32'(underrun_cnt), 32'(e_cnt));
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
    model_update();
    compare_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    int cnt_l;

    RESET = 1'b1; s_valid = 1'b0; s_left = '0; s_right = '0;
    t = 0; m_full = 0; e_cnt = 0; e_dac = 0; e_fs = 0; e_ur = 0;
    cur_l = '0; cur_r = '0; m_hold_l = '0; m_hold_r = '0;
    repeat (3) step();

    // Known pair loaded before frame 0
    RESET = 1'b0;
    s_valid = 1'b1; s_left = FIRST_L; s_right = FIRST_R;
    step();
    s_valid = 1'b0;
    for (int i = 0; i < FRAME * 3; i++) step();

    // Random valid pattern and data
    for (int i = 0; i < FRAME * 16; i++) begin
      s_valid = ($urandom_range(0, 2) == 0);
      s_left  = SW'($urandom);
      s_right = SW'($urandom);
      step();
    end

    // s_valid held high, pairs advance only when accepted
    cnt_l = 16'h0100;
    s_valid = 1'b1;
    s_left = SW'(cnt_l); s_right = ~SW'(cnt_l);
    for (int i = 0; i < FRAME * 8; i++) begin
      found = !m_full;
      step();
      if (found) begin
        cnt_l++;
        s_left = SW'(cnt_l); s_right = ~SW'(cnt_l);
      end
    end
    s_valid = 1'b0;

    // Starvation until the counter saturates
    for (int i = 0; i < FRAME * 300; i++) step();
    check_val("ur_sat", 32'(underrun_cnt), 32'd255);

    // Reset in the middle of a right slot
    for (int i = 0; i < FRAME * 2; i++) begin
      if ((t / FALL_PER) > 0 && ((t / FALL_PER - 1) % SLOTS2) >= SL + 3) break;
      step();
    end
    s_valid = 1'b1; s_left = 16'h1234; s_right = 16'h5678;
    step();
    s_valid = 1'b0;
    RESET = 1'b1;
    step();
    check_val("mrst_bclk",  32'(AUD_BCLK),    32'd0);
    check_val("mrst_lrck",  32'(AUD_DACLRCK), 32'd1);
    check_val("mrst_dac",   32'(AUD_DACDAT),  32'd0);
    check_val("mrst_ready", 32'(s_ready),     32'd1);
    RESET = 1'b0;
    n = 0; found = 0;
    for (int i = 0; i < 8 * CD && !found; i++) begin
      step();
      n++;
      if (frame_start) found = 1;
    end
    check_val("fs_latency", 32'(n), 32'(2 * CD));

    for (int i = 0; i < FRAME * 4; i++) begin
      s_valid = ($urandom_range(0, 1) == 0);
      s_left  = SW'($urandom);
      s_right = SW'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
